// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART echo tester: FSM and
//               receiver state encodings, 8N1 frame sizes, helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Saturating add of a small increment to an 8-bit error counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_rx
// Description : 8N1 UART receiver: 2-FF synchronizer, falling-edge start
//               detection with mid-bit glitch reject, mid-bit data/stop
//               sampling, one-cycle valid pulse with framing error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic [7:0]      byte_q, byte_d;
    logic            ferr_q, ferr_d;

    // Synchronize the asynchronous line and keep one delayed copy for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing: start re-check at half bit, then one sample per bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        byte_d  = byte_q;
        ferr_d  = ferr_q;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line already high again at mid start bit was a glitch.
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    byte_d  = shift_q;
                    ferr_d  = !sync2_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_valid_o  = valid_q;
    assign rx_byte_o   = byte_q;
    assign frame_err_o = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_echo_tester.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_tester
// Description : UART echo initiator: sends SEED, SEED+1, ... on tx, checks
//               each echo received on rx, reports pass/fail/timeout and a
//               saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_tester
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter logic [7:0] SEED           = 8'h41
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] num_bytes,
    input  logic       rx,
    output logic       tx,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic       timeout,
    output logic [7:0] err_count,
    output logic [7:0] last_sent,
    output logic [7:0] last_rcvd
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_frame_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx),
        .rx_valid_o  (rx_valid),
        .rx_byte_o   (rx_byte),
        .frame_err_o (rx_ferr)
    );

    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    last_sent_q, last_sent_d;
    logic [7:0]    last_rcvd_q, last_rcvd_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    remain_q, remain_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          hold_valid_q, hold_valid_d;
    logic [7:0]    hold_byte_q, hold_byte_d;
    logic          hold_ferr_q, hold_ferr_d;
    logic [1:0]    err_inc;

    // State register for the FSM, serializer, checker and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            tmo_flag_q   <= 1'b0;
            err_q        <= '0;
            last_sent_q  <= '0;
            last_rcvd_q  <= '0;
            byte_q       <= '0;
            remain_q     <= '0;
            shift_q      <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            active_q     <= 1'b0;
            tmo_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_byte_q  <= '0;
            hold_ferr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            tmo_flag_q   <= tmo_flag_d;
            err_q        <= err_d;
            last_sent_q  <= last_sent_d;
            last_rcvd_q  <= last_rcvd_d;
            byte_q       <= byte_d;
            remain_q     <= remain_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            tmo_q        <= tmo_d;
            hold_valid_q <= hold_valid_d;
            hold_byte_q  <= hold_byte_d;
            hold_ferr_q  <= hold_ferr_d;
        end
    end

    // Next-state logic: run sequencing, bit serializer, echo check, frame holding.
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        tmo_flag_d   = tmo_flag_q;
        err_d        = err_q;
        last_sent_d  = last_sent_q;
        last_rcvd_d  = last_rcvd_q;
        byte_d       = byte_q;
        remain_d     = remain_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        tmo_d        = tmo_q;
        hold_valid_d = hold_valid_q;
        hold_byte_d  = hold_byte_q;
        hold_ferr_d  = hold_ferr_q;
        err_inc      = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remain_d     = num_bytes;
                    pass_d       = 1'b0;
                    fail_d       = 1'b0;
                    tmo_flag_d   = 1'b0;
                    err_d        = '0;
                    busy_d       = 1'b1;
                    byte_d       = SEED;
                    active_d     = 1'b0;
                    hold_valid_d = 1'b0;
                    state_d      = (num_bytes == 8'd0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (!active_q) begin
                    // First SEND cycle launches the start bit on the next edge.
                    active_d    = 1'b1;
                    tx_d        = 1'b0;
                    shift_d     = byte_q;
                    bit_d       = '0;
                    cnt_d       = '0;
                    last_sent_d = byte_q;
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'(FRAME_BITS - 1)) begin
                        active_d = 1'b0;
                        tmo_d    = '0;
                        state_d  = ST_WAIT_ECHO;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 4'(DATA_BITS)) begin
                            tx_d = 1'b1;
                        end else begin
                            tx_d    = shift_q[0];
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_ECHO: begin
                if (hold_valid_q) begin
                    state_d = ST_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_flag_d = 1'b1;
                    fail_d     = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (hold_ferr_q || (hold_byte_q != byte_q)) begin
                    err_inc = err_inc + 2'd1;
                end
                if (remain_q > 8'd1) begin
                    remain_d = remain_q - 1'b1;
                    byte_d   = byte_q + 1'b1;
                    state_d  = ST_SEND;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                pass_d  = (err_q == 8'd0) && !tmo_flag_q;
                fail_d  = !((err_q == 8'd0) && !tmo_flag_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // CHECK consumes the held frame; a newer frame always wins the slot.
        if (state_q == ST_CHECK) begin
            hold_valid_d = 1'b0;
        end
        if (rx_valid) begin
            last_rcvd_d = rx_byte;
            if (state_q != ST_IDLE && state_q != ST_DONE) begin
                if (hold_valid_q && state_q != ST_CHECK) begin
                    err_inc = err_inc + 2'd1;
                end
                hold_valid_d = 1'b1;
                hold_byte_d  = rx_byte;
                hold_ferr_d  = rx_ferr;
            end
        end
        err_d = sat_add8(err_d, err_inc);
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = tmo_flag_q;
    assign err_count = err_q;
    assign last_sent = last_sent_q;
    assign last_rcvd = last_rcvd_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_echo_tester
// Description : Self-checking bench for uart_echo_tester: loopback, corrupted
//               echoes, timeout, glitch reject, reset mid-frame, seed wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_tester;

    localparam int CPB = 16;
    localparam logic [2:0] M_LOOP = 3'd0, M_FLIP = 3'd1, M_STOP0 = 3'd2,
                           M_HIGH = 3'd3, M_GLITCH = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_bytes = 8'd0;
    logic       tx, busy, pass, fail, timeout;
    logic [7:0] err_count, last_sent, last_rcvd;
    logic       rx_w;

    logic       start2 = 1'b0;
    logic [7:0] num2 = 8'd0;
    logic       tx2, busy2, pass2, fail2, timeout2;
    logic [7:0] err2, last_sent2, last_rcvd2;

    logic [2:0] mode = M_LOOP;
    logic       glitch_v = 1'b1;
    int         tgt_frame = 0, tgt_bit = 0;

    int n_chk = 0, n_err = 0;
    logic [7:0] sb[$];
    logic [7:0] sb2[$];

    int         m_cnt = 0, m_frame = 0;
    logic       m_active = 1'b0;
    logic [7:0] m_byte = 8'd0;
    logic [7:0] ls2_prev = 8'd0;
    int         rxv_cnt = 0;
    logic       corrupt;

    always #5 clk = ~clk;

    assign corrupt = m_active && (m_frame == tgt_frame) && ((m_cnt / CPB) == tgt_bit);
    assign rx_w = (mode == M_HIGH)   ? 1'b1 :
                  (mode == M_GLITCH) ? glitch_v :
                  (mode == M_STOP0)  ? (corrupt ? 1'b0 : tx) :
                  (mode == M_FLIP)   ? (tx ^ corrupt) : tx;

    uart_echo_tester #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(500), .SEED(8'h41)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes), .rx(rx_w),
        .tx(tx), .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
        .err_count(err_count), .last_sent(last_sent), .last_rcvd(last_rcvd)
    );

    uart_echo_tester #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(500), .SEED(8'hFF)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .num_bytes(num2), .rx(tx2),
        .tx(tx2), .busy(busy2), .pass(pass2), .fail(fail2), .timeout(timeout2),
        .err_count(err2), .last_sent(last_sent2), .last_rcvd(last_rcvd2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Decode every frame on tx and compare it with the scoreboard head.
    always @(negedge clk) begin
        if (start) m_frame = 0;
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (!tx) begin
                m_active = 1'b1;
                m_cnt    = 0;
            end
        end else begin
            m_cnt++;
        end
        if (m_active && !rst) begin
            if ((m_cnt % CPB) == CPB / 2) begin
                if ((m_cnt / CPB) >= 1 && (m_cnt / CPB) <= 8) m_byte[(m_cnt / CPB) - 1] = tx;
                if ((m_cnt / CPB) == 0) chk("tx_start_bit", {31'd0, tx}, 32'd0);
                if ((m_cnt / CPB) == 9) begin
                    chk("tx_stop_bit", {31'd0, tx}, 32'd1);
                    if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                    else chk("tx_byte", {24'd0, m_byte}, {24'd0, sb.pop_front()});
                    chk("last_sent", {24'd0, last_sent}, {24'd0, m_byte});
                end
            end
            if (m_cnt == 10 * CPB - 1) begin
                m_active = 1'b0;
                m_frame++;
            end
        end
    end

    // Byte sequence of the wrapping-seed instance, observed through last_sent.
    always @(negedge clk) begin
        if (!rst && last_sent2 != ls2_prev) begin
            if (sb2.size() == 0) chk("sb2_underflow", 32'd1, 32'd0);
            else chk("seed_wrap_byte", {24'd0, last_sent2}, {24'd0, sb2.pop_front()});
        end
        ls2_prev = last_sent2;
    end

    // Count completed receiver frames for the glitch check.
    always @(posedge clk) begin
        if (u_dut.rx_valid) rxv_cnt++;
    end

    task automatic run_dut(input int n);
        num_bytes = n[7:0];
        for (int i = 0; i < n; i++) sb.push_back(8'(8'h41 + i));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input bit poke, output int cyc);
        cyc = 0;
        for (int g = 0; g < 5000 && busy; g++) begin
            @(negedge clk);
            if (busy) cyc++;
            if (poke && cyc == 300) begin start = 1'b1; num_bytes = 8'd9; end
            else if (poke && cyc == 301) start = 1'b0;
        end
        chk("busy_bound", {31'd0, busy}, 32'd0);
        start = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic p, input logic f,
                              input logic t, input logic [7:0] e, input logic [7:0] lr);
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
        chk({tag, "_fail"}, {31'd0, fail}, {31'd0, f});
        chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, t});
        chk({tag, "_err"}, {24'd0, err_count}, {24'd0, e});
        chk({tag, "_last_rcvd"}, {24'd0, last_rcvd}, {24'd0, lr});
        chk({tag, "_sb_left"}, sb.size(), 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tx"}, {31'd0, tx}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        chk({tag, "_err"}, {24'd0, err_count}, 32'd0);
        chk({tag, "_last_sent"}, {24'd0, last_sent}, 32'd0);
        chk({tag, "_last_rcvd"}, {24'd0, last_rcvd}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int g;
        int snap;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_values("reset");

        // Loopback, 4 bytes, with a start pulse mid-run that must be ignored.
        mode = M_LOOP;
        run_dut(4);
        wait_idle(1'b1, cyc);
        chk_result("loop4", 1'b1, 1'b0, 1'b0, 8'h00, 8'h44);
        chk("loop4_last_sent", {24'd0, last_sent}, 32'h44);
        chk("loop4_busy_cycles", {31'd0, (cyc >= 645 && cyc <= 665)}, 32'd1);

        // Bit 0 of the second echo flipped.
        mode = M_FLIP; tgt_frame = 1; tgt_bit = 1;
        run_dut(3);
        wait_idle(1'b0, cyc);
        chk_result("flip", 1'b0, 1'b1, 1'b0, 8'h01, 8'h43);

        // Stop bit of the first echo driven low.
        mode = M_STOP0; tgt_frame = 0; tgt_bit = 9;
        run_dut(2);
        wait_idle(1'b0, cyc);
        chk_result("stop0", 1'b0, 1'b1, 1'b0, 8'h01, 8'h42);

        // Two-cycle low glitch while idle must not complete a frame.
        glitch_v = 1'b1; mode = M_GLITCH;
        repeat (4) @(posedge clk);
        snap = rxv_cnt;
        #1 glitch_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 glitch_v = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        chk("glitch_rx_valid", rxv_cnt - snap, 32'd0);
        chk("glitch_last_rcvd", {24'd0, last_rcvd}, 32'h42);

        // No echo: timeout 500 cycles after the first stop bit ends.
        mode = M_HIGH;
        num_bytes = 8'd2;
        sb.push_back(8'h41);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (g = 0; g < 100 && tx; g++) @(negedge clk);
        chk("tmo_tx_started", {31'd0, tx}, 32'd0);
        cyc = 0;
        for (g = 0; g < 2000 && !timeout; g++) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_latency", cyc, 32'd660);
        wait_idle(1'b0, cyc);
        repeat (3 * 10 * CPB) @(negedge clk);
        chk_result("tmo", 1'b0, 1'b1, 1'b1, 8'h00, 8'h42);

        // Reset in the middle of data bit 2 of the second byte, with start held.
        mode = M_LOOP;
        run_dut(4);
        for (g = 0; g < 3000 && !(m_frame == 1 && m_active && m_cnt == 3 * CPB + CPB / 2); g++)
            @(negedge clk);
        chk("rst_reached_frame2", {31'd0, (m_frame == 1 && m_active)}, 32'd1);
        @(posedge clk); #1 rst = 1'b1; start = 1'b1; num_bytes = 8'd5;
        @(posedge clk); #1;
        chk_reset_values("midrst");
        rst = 1'b0; start = 1'b0;
        sb.delete();
        repeat (20) @(negedge clk);
        chk("midrst_busy_after", {31'd0, busy}, 32'd0);
        chk("midrst_tx_after", {31'd0, tx}, 32'd1);

        // Seed 8'hFF wraps to 8'h00.
        sb2.push_back(8'hFF);
        sb2.push_back(8'h00);
        num2 = 8'd2;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (g = 0; g < 5000 && busy2; g++) @(negedge clk);
        chk("wrap_busy_bound", {31'd0, busy2}, 32'd0);
        chk("wrap_pass", {31'd0, pass2}, 32'd1);
        chk("wrap_fail", {31'd0, fail2}, 32'd0);
        chk("wrap_err", {24'd0, err2}, 32'd0);
        chk("wrap_last_rcvd", {24'd0, last_rcvd2}, 32'h00);
        chk("wrap_sb_left", sb2.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
